tri_inside: RTL and testbench

Triangle containment stage that sits directly downstream of `p_hit`. It pops one hit point P (Q16.16 x/y/z) from the `p_hit` output FIFO and one triangle record (v0, v1, v2, normal) from the triangle FIFO, then runs the three edge-side tests on a single shared cross/dot datapath. It emits a one-bit hit flag together with the pass-through P in a single-entry show-ahead output register.

---
 rtl/tri_inside.sv | 153 +++++++++++++++
 tb/tb_tri_inside.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tri_inside.sv
// tri_inside: point-in-triangle containment stage downstream of p_hit.
// Pops one hit point P and one triangle record together. It then runs three
// edge-side tests on one shared cross/dot datapath. Each test takes two
// cycles, a CROSS cycle and then a DOT cycle. The block emits a hit flag and
// the pass-through P through a single-entry show-ahead output register.
//
// Ports:
//   clock, reset          clock; asynchronous active-low reset
//   p, p_empty, p_rd_en   show-ahead hit point FIFO (Q16.16 x/y/z)
//   v0, v1, v2,
//   tri_normal,
//   tri_empty, tri_rd_en  show-ahead triangle FIFO
//   out_hit, out_p        result: inside/on-boundary flag, P unchanged
//   out_empty, out_rd_en  output register status and consumer pop
module tri_inside #(
  parameter int unsigned Q_BITS = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic signed [31:0] p [2:0],
  input  logic               p_empty,
  output logic               p_rd_en,
  input  logic signed [31:0] v0 [2:0],
  input  logic signed [31:0] v1 [2:0],
  input  logic signed [31:0] v2 [2:0],
  input  logic signed [31:0] tri_normal [2:0],
  input  logic               tri_empty,
  output logic               tri_rd_en,
  output logic               out_hit,
  output logic signed [31:0] out_p [2:0],
  output logic               out_empty,
  input  logic               out_rd_en
);

  typedef enum logic [1:0] {IDLE, CROSS, DOT} state_t;

  state_t             state;
  logic [1:0]         k_q;
  logic               inside_q;
  logic signed [31:0] p_q  [2:0];
  logic signed [31:0] v0_q [2:0];
  logic signed [31:0] v1_q [2:0];
  logic signed [31:0] v2_q [2:0];
  logic signed [31:0] n_q  [2:0];
  logic signed [31:0] x_q  [2:0];

  logic               start;
  logic signed [31:0] a [2:0];
  logic signed [31:0] b [2:0];
  logic signed [31:0] e [2:0];
  logic signed [31:0] c [2:0];
  logic signed [63:0] d [2:0];
  logic signed [31:0] x_next [2:0];
  logic signed [65:0] dot_s;
  logic               edge_ok;

  function automatic logic signed [63:0] mul(input logic signed [31:0] l,
                                             input logic signed [31:0] r);
    logic signed [63:0] le;
    logic signed [63:0] re;
    le = 64'(l);
    re = 64'(r);
    return le * re;
  endfunction

  // Reset is included so that both pops stay low for the whole reset
  // window, even while the FIFOs report data.
  assign start     = reset && (state == IDLE) && !p_empty && !tri_empty && out_empty;
  assign p_rd_en   = start;
  assign tri_rd_en = start;

  // Edge endpoints for edge k: (v0,v1), (v1,v2), (v2,v0)
  always_comb begin
    a = v0_q;
    b = v1_q;
    case (k_q)
      2'd1: begin a = v1_q; b = v2_q; end
      2'd2: begin a = v2_q; b = v0_q; end
      default: ;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      e[i] = b[i] - a[i];
      c[i] = p_q[i] - a[i];
    end
    d[0] = mul(e[1], c[2]) - mul(e[2], c[1]);
    d[1] = mul(e[2], c[0]) - mul(e[0], c[2]);
    d[2] = mul(e[0], c[1]) - mul(e[1], c[0]);
    for (int unsigned i = 0; i < 3; i++) begin
      x_next[i] = 32'(d[i] >>> Q_BITS);
    end
  end

  // Full-precision dot product; only its sign is used.
  always_comb begin
    dot_s   = 66'(mul(n_q[0], x_q[0])) + 66'(mul(n_q[1], x_q[1]))
            + 66'(mul(n_q[2], x_q[2]));
    edge_ok = ~dot_s[65];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      k_q       <= '0;
      inside_q  <= 1'b1;
      out_empty <= 1'b1;
      out_hit   <= 1'b0;
      out_p     <= '{default: '0};
      p_q       <= '{default: '0};
      v0_q      <= '{default: '0};
      v1_q      <= '{default: '0};
      v2_q      <= '{default: '0};
      n_q       <= '{default: '0};
      x_q       <= '{default: '0};
    end else begin
      if (out_rd_en && !out_empty) out_empty <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            p_q      <= p;
            v0_q     <= v0;
            v1_q     <= v1;
            v2_q     <= v2;
            n_q      <= tri_normal;
            k_q      <= '0;
            inside_q <= 1'b1;
            state    <= CROSS;
          end
        end
        CROSS: begin
          x_q   <= x_next;
          state <= DOT;
        end
        DOT: begin
          inside_q <= inside_q & edge_ok;
          if (k_q == 2'd2) begin
            out_hit   <= inside_q & edge_ok;
            out_p     <= p_q;
            out_empty <= 1'b0;
            state     <= IDLE;
          end else begin
            k_q   <= k_q + 2'd1;
            state <= CROSS;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_inside.sv
module tb_tri_inside;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic signed [31:0] p [2:0];
  logic signed [31:0] v0 [2:0];
  logic signed [31:0] v1 [2:0];
  logic signed [31:0] v2 [2:0];
  logic signed [31:0] tri_normal [2:0];
  logic signed [31:0] out_p [2:0];
  logic p_empty, tri_empty, p_rd_en, tri_rd_en;
  logic out_hit, out_empty, out_rd_en;

  int checks   = 0;
  int failures = 0;

  tri_inside #(.Q_BITS(16)) dut (
    .clock(clock), .reset(reset),
    .p(p), .p_empty(p_empty), .p_rd_en(p_rd_en),
    .v0(v0), .v1(v1), .v2(v2), .tri_normal(tri_normal),
    .tri_empty(tri_empty), .tri_rd_en(tri_rd_en),
    .out_hit(out_hit), .out_p(out_p),
    .out_empty(out_empty), .out_rd_en(out_rd_en)
  );

  // Coordinates in quarter units; tsel picks the triangle.
  typedef struct {
    int px, py, pz;
    int tsel;
    bit hit;
  } vec_t;

  vec_t tv [11];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic signed [31:0] q(input int x);
    return 32'(x * 16384);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input vec_t t);
    p[0] = q(t.px); p[1] = q(t.py); p[2] = q(t.pz);
    for (int i = 0; i < 3; i++) begin
      v0[i] = '0; v1[i] = '0; v2[i] = '0; tri_normal[i] = '0;
    end
    case (t.tsel)
      1: begin v1[0] = q(8); v2[1] = q(8); tri_normal[2] = q(4); end
      2: begin v1[1] = q(4); v2[2] = q(4); tri_normal[0] = q(4); end
      3: begin v1[2] = q(4); v2[0] = q(4); tri_normal[1] = q(4); end
      default: begin v1[0] = q(4); v2[1] = q(4); tri_normal[2] = q(4); end
    endcase
  endtask

  // Called in cycle N+1 (one step after the pop). Checks the fixed latency and
  // the result, then consumes it.
  task automatic wait_res(input vec_t t, input bit chk_x, input string tag);
    int lat;
    lat = 1;
    while (out_empty && lat < 20) begin
      if (chk_x && lat == 2) chk({tag, "_cross0_z"}, 96'(dut.x_q[2]), 96'h4000);
      step();
      lat++;
    end
    chk({tag, "_latency"}, 96'(lat), 96'd7);
    chk({tag, "_hit"}, 96'(out_hit), 96'(t.hit));
    chk({tag, "_out_p"}, {out_p[2], out_p[1], out_p[0]}, {q(t.pz), q(t.py), q(t.px)});
    out_rd_en = 1'b1;
    step();
    out_rd_en = 1'b0;
    chk({tag, "_drain"}, 96'(out_empty), 96'd1);
  endtask

  task automatic run_item(input vec_t t, input bit chk_x, input string tag);
    int n;
    load(t);
    p_empty = 1'b0; tri_empty = 1'b0;
    #1;
    n = 0;
    while (!(p_rd_en || tri_rd_en) && n < 20) begin step(); n++; end
    chk({tag, "_pop_pair"}, 96'({p_rd_en, tri_rd_en}), 96'b11);
    step();
    p_empty = 1'b1; tri_empty = 1'b1;
    #1;
    chk({tag, "_pop_single"}, 96'({p_rd_en, tri_rd_en}), 96'b00);
    wait_res(t, chk_x, tag);
  endtask

  initial begin
    int extra, bad;

    tv[0]  = '{1, 1, 0, 0, 1};    // interior
    tv[1]  = '{4, 4, 0, 0, 0};    // exterior, edge 1 negative
    tv[2]  = '{2, 0, 0, 0, 1};    // on edge 0
    tv[3]  = '{4, 0, 0, 0, 1};    // on vertex v1
    tv[4]  = '{-1, 1, 0, 0, 0};   // outside edge 2 only
    tv[5]  = '{1, -1, 0, 0, 0};   // outside edge 0 only, later edges pass
    tv[6]  = '{4, 2, 20, 1, 1};   // larger triangle, off-plane z
    tv[7]  = '{6, 6, 0, 1, 0};    // larger triangle, exterior
    tv[8]  = '{0, 1, 1, 2, 1};    // x=0 plane, interior
    tv[9]  = '{0, -1, 1, 2, 0};   // x=0 plane, exterior
    tv[10] = '{1, 0, 1, 3, 1};    // y=0 plane, interior

    reset = 1'b0;
    p_empty = 1'b0; tri_empty = 1'b0; out_rd_en = 1'b0;
    load(tv[0]);
    #12;
    chk("rst_out_empty", 96'(out_empty), 96'd1);
    chk("rst_out_hit", 96'(out_hit), 96'd0);
    chk("rst_out_p", {out_p[2], out_p[1], out_p[0]}, 96'd0);
    chk("rst_rd_en", 96'({p_rd_en, tri_rd_en}), 96'b00);
    p_empty = 1'b1; tri_empty = 1'b1;
    step();
    reset = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      run_item(tv[i], (i == 0), $sformatf("vec%0d", i));
    end

    // Back-pressure: two items queued, consumer stalls.
    load(tv[0]);
    p_empty = 1'b0; tri_empty = 1'b0;
    #1;
    chk("bp_pop1", 96'({p_rd_en, tri_rd_en}), 96'b11);
    step();
    load(tv[1]);
    extra = 0; bad = 0;
    for (int i = 0; i < 27; i++) begin
      if (p_rd_en || tri_rd_en) extra++;
      if (i >= 6 && out_empty) bad++;
      step();
    end
    chk("bp_no_second_pop", 96'(extra), 96'd0);
    chk("bp_held_full", 96'(bad), 96'd0);
    chk("bp_hit1", 96'(out_hit), 96'd1);
    out_rd_en = 1'b1;
    step();
    out_rd_en = 1'b0;
    chk("bp_empty_after_read", 96'(out_empty), 96'd1);
    chk("bp_pop2", 96'({p_rd_en, tri_rd_en}), 96'b11);
    step();
    p_empty = 1'b1; tri_empty = 1'b1;
    wait_res(tv[1], 1'b0, "bp_item2");

    // Empty gating: triangle FIFO empty holds the block idle.
    load(tv[2]);
    p_empty = 1'b0; tri_empty = 1'b1;
    extra = 0; bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (p_rd_en || tri_rd_en) extra++;
      if (!out_empty) bad++;
      step();
    end
    chk("gate_no_pop", 96'(extra), 96'd0);
    chk("gate_idle", 96'(bad), 96'd0);
    tri_empty = 1'b0;
    out_rd_en = 1'b1;              // read while empty must be ignored
    #1;
    chk("gate_pop_pair", 96'({p_rd_en, tri_rd_en}), 96'b11);
    step();
    out_rd_en = 1'b0;
    p_empty = 1'b1; tri_empty = 1'b1;
    #1;
    chk("gate_pop_single", 96'({p_rd_en, tri_rd_en}), 96'b00);
    wait_res(tv[2], 1'b0, "gate");

    // Reset during DOT1; out_hit/out_p still hold the previous nonzero result.
    load(tv[4]);
    p_empty = 1'b0; tri_empty = 1'b0;
    #1;
    chk("rm_pop", 96'({p_rd_en, tri_rd_en}), 96'b11);
    step();                        // N+1
    load(tv[0]);                   // next queued item
    step(); step(); step();        // N+4, DOT1
    reset = 1'b0;
    #1;
    chk("rm_out_empty", 96'(out_empty), 96'd1);
    chk("rm_out_hit", 96'(out_hit), 96'd0);
    chk("rm_out_p", {out_p[2], out_p[1], out_p[0]}, 96'd0);
    extra = 0; bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (p_rd_en || tri_rd_en) extra++;
      if (!out_empty) bad++;
      step();
    end
    chk("rm_no_pop_in_reset", 96'(extra), 96'd0);
    chk("rm_no_result", 96'(bad), 96'd0);
    reset = 1'b1;
    #1;
    chk("rm_restart_pop", 96'({p_rd_en, tri_rd_en}), 96'b11);
    step();
    p_empty = 1'b1; tri_empty = 1'b1;
    wait_res(tv[0], 1'b0, "rm_next");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
